// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared encodings and constants for the multiply/divide sequencer
package md_pkg;

  // md_op encodings driven by the E-stage decode; 6 and 7 are reserved no-ops
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // Sequencer state encoding
  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_RUN  = 1'b1;

  // Default busy durations in cycles
  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // True for the four operations that occupy the unit for multiple cycles
  function automatic logic md_is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the two divide operations (selects the longer latency)
  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Counter width: at least 4 bits, and wide enough to hold the larger latency
  function automatic int md_cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = 4;
    while ((1 << w) <= m) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational multiply/divide datapath producing the pending HI/LO pair
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  i_md_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [63:0] o_res
);

  logic signed [63:0] w_smul;
  logic        [63:0] w_umul;
  logic               w_rt_zero;
  logic               w_ovf;
  logic        [31:0] w_dvsr;
  logic signed [31:0] w_squo;
  logic signed [31:0] w_srem;
  logic        [31:0] w_uquo;
  logic        [31:0] w_urem;

  // Sign- or zero-extend to 64 bits so the low 64 bits of the product are exact
  assign w_smul = $signed({{32{i_rs[31]}}, i_rs}) * $signed({{32{i_rt[31]}}, i_rt});
  assign w_umul = {32'd0, i_rs} * {32'd0, i_rt};

  // Zero divisor and the single signed overflow case are resolved explicitly;
  // the divider sees a harmless divisor of 1 so it never faults or goes undefined.
  assign w_rt_zero = (i_rt == 32'd0);
  assign w_ovf     = (i_rs == 32'h8000_0000) && (i_rt == 32'hFFFF_FFFF);
  assign w_dvsr    = (w_rt_zero || w_ovf) ? 32'd1 : i_rt;

  // Signed divide truncates toward zero; remainder follows the dividend's sign
  assign w_squo = $signed(i_rs) / $signed(w_dvsr);
  assign w_srem = $signed(i_rs) % $signed(w_dvsr);
  assign w_uquo = i_rs / w_dvsr;
  assign w_urem = i_rs % w_dvsr;

  // Select the 64-bit {hi,lo} result; anything else keeps the current HI/LO
  always_comb begin
    o_res = {i_hi, i_lo};
    case (i_md_op)
      MD_MULT:  o_res = w_smul;
      MD_MULTU: o_res = w_umul;
      MD_DIV: begin
        if (w_rt_zero) begin
          o_res = {i_hi, i_lo};
        end else if (w_ovf) begin
          o_res = {32'd0, 32'h8000_0000};
        end else begin
          o_res = {w_srem, w_squo};
        end
      end
      MD_DIVU: begin
        if (w_rt_zero) begin
          o_res = {i_hi, i_lo};
        end else begin
          o_res = {w_urem, w_uquo};
        end
      end
      default: o_res = {i_hi, i_lo};
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - fixed-latency multiply/divide sequencer with HI/LO and D-stage stall
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = md_cnt_width(MULT_CYCLES, DIV_CYCLES);

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_p_hi;
  logic [31:0]   r_p_lo;

  logic [63:0]   w_res;
  logic          w_arith;
  logic [CW-1:0] w_lat_m1;

  md_arith u_arith (
    .i_md_op (md_op),
    .i_rs    (rs_val),
    .i_rt    (rt_val),
    .i_hi    (r_hi),
    .i_lo    (r_lo),
    .o_res   (w_res)
  );

  assign w_arith  = md_is_arith(md_op);
  assign w_lat_m1 = md_is_div(md_op) ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);

  // A D-stage HI/LO user must wait while the unit is busy or about to become busy
  assign stall = d_md_use & (r_busy | (start & w_arith));

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // FSM, down-counter, pending result and architectural HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_p_hi  <= 32'd0;
      r_p_lo  <= 32'd0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (start) begin
            if (w_arith) begin
              r_p_hi  <= w_res[63:32];
              r_p_lo  <= w_res[31:0];
              r_cnt   <= w_lat_m1;
              r_busy  <= 1'b1;
              r_state <= MD_RUN;
            end else if (md_op == MD_MTHI) begin
              r_hi <= rs_val;
            end else if (md_op == MD_MTLO) begin
              r_lo <= rs_val;
            end
          end
        end
        MD_RUN: begin
          // start is ignored here; the stall output keeps new md ops out of E
          if (r_cnt == '0) begin
            r_hi    <= r_p_hi;
            r_lo    <= r_p_lo;
            r_busy  <= 1'b0;
            r_state <= MD_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= MD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle multiply/divide sequencer for the pipelined MIPS core's E stage. It accepts `mult`/`multu`/`div`/`divu`/`mthi`/`mtlo` from the E-stage decode, computes the result and holds the HI/LO architectural registers. It keeps `busy` asserted for a fixed latency, and generates the D-stage stall request that prevents any HI/LO-related instruction from entering E while an operation is outstanding.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy duration for `mult`/`multu`; must be ≥1.
- `DIV_CYCLES`, default 10: busy duration for `div`/`divu`; must be ≥1.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  E-stage instruction is a valid md operation this cycle.
- `md_op`  in  3  operation code: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6–7 reserved (no-op).
- `rs_val`  in  32  forwarded rs operand.
- `rt_val`  in  32  forwarded rt operand.
- `d_md_use`  in  1  D-stage instruction is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- `busy`  out  1  registered; operation in progress.
- `stall`  out  1  combinational: `d_md_use & (busy | (start & md_op<=3))`.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, RUN. A down-counter `cnt` (4 bits minimum, wide enough for max(MULT_CYCLES, DIV_CYCLES)) tracks the remaining cycles.
- IDLE, `start` & md_op ∈ {0..3}:
  - compute the 64-bit result into pending registers `p_hi`/`p_lo`;
  - load `cnt` = latency−1;
  - go to RUN.
- Arithmetic:
  - MULT: signed 32×32→64; `{p_hi,p_lo}` = product.
  - MULTU: unsigned 32×32→64; `{p_hi,p_lo}` = product.
  - DIV: `p_lo`=quotient, `p_hi`=remainder, C-style truncation; the remainder takes the sign of the dividend (rs).
  - DIVU: unsigned; same assignment.
  - Divide with rt=0: `p_hi`←`hi`, `p_lo`←`lo`, so HI/LO are unchanged at commit. Full latency still applies.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- IDLE, `start` & MTHI: `hi`←rs_val at the edge. No busy. Stays in IDLE.
- IDLE, `start` & MTLO: `lo`←rs_val at the edge. No busy. Stays in IDLE.
- IDLE, reserved md_op: ignored.
- RUN:
  - `cnt` decrements each edge;
  - at the edge where `cnt`==0, commit `hi`←`p_hi`, `lo`←`p_lo` and go to IDLE.
- `start` while RUN: ignored entirely, including MTHI/MTLO. The pipeline guarantees this cannot happen via `stall`.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, state=IDLE, `cnt`=0, `p_hi`=`p_lo`=0.
- A reset asserted mid-operation aborts the operation; the pending result is discarded.
- Acceptance edge E0 (`start` high in IDLE, latency N):
  - `busy` is high from E0 until edge E0+N;
  - `busy` is high for exactly N cycles;
  - HI/LO take their new values at edge E0+N, the same edge at which `busy` falls.
- A new `start` is accepted in the first cycle with `busy`=0, giving back-to-back operations with no idle bubble.
- MTHI/MTLO take effect at the accepting edge. An `mfhi` issued in the following cycle reads the new value.
- `stall` is purely combinational. In the cycle a mult/div sits in E with `start` high, a D-stage md-user is already stalled.
- `hi`/`lo` are register outputs with no combinational path from inputs.

## Structure
- Shared package `md_pkg`:
  - md_op encodings (`MD_MULT`…`MD_MTLO`);
  - state encoding (`MD_IDLE`, `MD_RUN`);
  - default latency constants.
- One sub-module `md_arith`: purely combinational. Inputs: md_op, rs, rt, current hi/lo. Outputs: 64-bit `{p_hi,p_lo}`. Implements all signed/unsigned and divide-by-zero rules, so the sequencer contains only FSM, counter and registers.

## Test plan
- MULT rs=0xFFFFFFFE (−2), rt=3: `busy` high for exactly 5 cycles; at the falling edge HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- DIV rs=−7 (0xFFFFFFF9), rt=2: `busy` for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=7, rt=2: LO=3, HI=1.
- MTHI 0x1234 and MTLO 0xABCD on consecutive cycles: `busy` stays 0; HI=0x1234 and LO=0xABCD one edge after each respective acceptance.
- Stall: `d_md_use`=1 during MULT acceptance and the 5 busy cycles gives `stall`=1 for 6 cycles; `d_md_use`=0 gives `stall`=0 throughout; a second MULT accepted the cycle `busy` drops shows no gap.
- Divide by zero with HI=0x11, LO=0x22: `busy` for 10 cycles; HI/LO remain 0x11/0x22.
- Reset asserted at busy cycle 3 of a DIV: `busy`, `hi`, `lo` go to 0 immediately without waiting for a clock edge; no commit occurs after reset is released.
